timer_bank: RTL and testbench
=============================

// Module: timer_bank
// PURPOSE
//  Parametrised bank of NUM_TIMERS CPU-programmable down-counting timers. It is the
//  successor to the single free-running millisecond timer: each channel adds a reload
//  value, one-shot or periodic mode, an expiry flag and an interrupt enable.
//  Sits on the Z80 memory map as one 256-byte page; dout feeds the cpu_din mux.
// PARAMETERS
//  NUM_TIMERS  4      number of channels, 1..16
//  COUNT_W     16     counter/reload width, 1..16; unused high bits read 0
//  TICK_DIV    24000  clk_sys cycles per timer tick (24000 = 1 ms at 24 MHz), >=1
// PORTS
//  clk_sys  in   1  system clock; all logic on its rising edge
//  reset_n  in   1  synchronous reset, active-low
//  cs       in   1  page select (cpu_addr[15:8] decode)
//  addr     in   8  cpu_addr[7:0]
//  rd_n     in   1  CPU read strobe, active-low
//  wr_n     in   1  CPU write strobe, active-low
//  din      in   8  CPU write data
//  dout     out  8  read data, combinational from registers; 0 when cs=0
//  irq_n    out  1  registered, low while any channel has (expired & IE)
// BEHAVIOUR
//  Reset: prescaler, count, reload, CTRL, expired and shadow are all 0; irq_n=1; dout=0.
//  Addressing: chan=addr[7:2], reg=addr[1:0]. If chan>=NUM_TIMERS, the read returns 0
//   and the write is ignored.
//  Registers: 0 CNT_L  R: count[7:0], and the same strobe latches count[15:8] into the
//                         channel shadow; W: reload[7:0]
//             1 CNT_H  R: shadow; W: reload[15:8]
//             2 CTRL   R/W: {5'b0, IE, PERIODIC, EN}
//             3 STATUS R: {7'b0, expired}; W: writing bit0=1 clears expired
//  Strobes are edge-detected:
//   rd_stb = cs & ~rd_n & ~rd_q; wr_stb = cs & ~wr_n & ~wr_q.
//   rd_q/wr_q are the previous-cycle values of cs&~rd_n and cs&~wr_n.
//   A held strobe acts exactly once.
//  Prescaler: shared, counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when it
//   equals TICK_DIV-1. It is never reset by CPU access.
//  Per channel, on tick with EN=1:
//   count!=0 -> count <= count-1
//   count==0 -> expired <= 1; PERIODIC: count <= reload; one-shot: EN <= 0, count stays 0
//   The period is therefore reload+1 ticks. Phase relative to EN-set is up to 1 tick.
//  CTRL write with EN 0->1: count <= reload on the same edge; a tick that cycle is
//   ignored for that channel. EN 1->0 freezes count.
//  Reload writes while running take effect only at the next reload or enable.
//  Simultaneous events:
//   - expiry set and STATUS clear in the same cycle -> expired = 1 (set wins)
//   - CTRL write and tick in the same cycle -> the CTRL write wins for EN/PERIODIC
//  Shadow latch uses the count value before that cycle's decrement.
//  irq_n updates 1 cycle after expired/IE change.
//  reset_n low mid-count: every register returns to its reset value on that edge.
//  Reload bytes are truncated to COUNT_W. All arithmetic is unsigned modulo 2^COUNT_W;
//   no underflow past 0.
// TESTING
//  1 Reset: run, assert reset_n=0 for 1 cycle -> every register reads 0x00, irq_n=1.
//  2 TICK_DIV=4, ch0 reload=2, CTRL=0x07 -> expired every 12 cycles, irq_n low
//    1 cycle later; write STATUS=0x01 -> irq_n high.
//  3 ch1 one-shot, reload=0, CTRL=0x01 -> expired on first tick, CTRL reads 0x00,
//    count stays 0.
//  4 Snapshot: count=0x0100, read CNT_L -> 0x00; a tick then gives count 0x00FF;
//    read CNT_H -> 0x01.
//  5 STATUS clear strobe on the expiry cycle -> expired stays 1. A held wr_n across
//    a later expiry does not clear it.
//  6 NUM_TIMERS=4: write addr 0x12 -> no state change, read 0x12 -> 0x00.
//    COUNT_W=10: write CNT_H=0xFF -> reload[9:8]=3, CNT_H reads at most 0x03.

Source files
------------

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank
//  Description : Bank of CPU-programmable down-counting timers on one 256-byte
//                Z80 page. Each channel has a reload value, one-shot or
//                periodic mode, a sticky expiry flag and an interrupt enable.
//                All channels share one tick prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_bank #(
    parameter int NUM_TIMERS = 4,
    parameter int COUNT_W    = 16,
    parameter int TICK_DIV   = 24000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cs,
    input  logic [7:0] addr,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq_n
);

    localparam int                 c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] c_REG_CNTL   = 2'd0;
    localparam logic [1:0] c_REG_CNTH   = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;
    localparam logic [1:0] c_REG_STATUS = 2'd3;

    // ------------------------------------------------------------------------
    // Bus strobes: a strobe held low for many cycles acts only on its first one
    // ------------------------------------------------------------------------
    logic       r_rd_q;
    logic       r_wr_q;
    logic       w_rd_act;
    logic       w_wr_act;
    logic       w_rd_stb;
    logic       w_wr_stb;
    logic [5:0] w_chan;
    logic [1:0] w_reg;

    assign w_rd_act = cs & ~rd_n;
    assign w_wr_act = cs & ~wr_n;
    assign w_rd_stb = w_rd_act & ~r_rd_q;
    assign w_wr_stb = w_wr_act & ~r_wr_q;
    assign w_chan   = addr[7:2];
    assign w_reg    = addr[1:0];

    // Remember last cycle's access levels for edge detection
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_rd_q <= 1'b0;
            r_wr_q <= 1'b0;
        end else begin
            r_rd_q <= w_rd_act;
            r_wr_q <= w_wr_act;
        end
    end

    // ------------------------------------------------------------------------
    // Shared prescaler: free-running, untouched by CPU accesses
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_presc == c_PRE_MAX);

    // Count 0..TICK_DIV-1 and wrap; the terminal value is the tick cycle
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Timer channels
    // ------------------------------------------------------------------------
    logic [NUM_TIMERS-1:0][7:0] w_rmask;
    logic [NUM_TIMERS-1:0]      w_irq_req;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        logic [COUNT_W-1:0] r_count;
        logic [COUNT_W-1:0] r_reload;
        logic [7:0]         r_shadow;
        logic               r_en;
        logic               r_per;
        logic               r_ie;
        logic               r_exp;
        logic               w_sel;
        logic               w_wr;
        logic               w_rd;
        logic               w_en_rise;
        logic [15:0]        w_count16;
        logic [15:0]        w_reload16;
        logic [7:0]         w_rdata;

        assign w_sel      = (w_chan == 6'(g));
        assign w_wr       = w_wr_stb & w_sel;
        assign w_rd       = w_rd_stb & w_sel;
        // Zero-extended views so byte lanes exist for any COUNT_W
        assign w_count16  = 16'(r_count);
        assign w_reload16 = 16'(r_reload);
        assign w_en_rise  = w_wr & (w_reg == c_REG_CTRL) & din[0] & ~r_en;

        // Channel state: register writes, countdown, expiry and snapshot
        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                r_count  <= '0;
                r_reload <= '0;
                r_shadow <= 8'h00;
                r_en     <= 1'b0;
                r_per    <= 1'b0;
                r_ie     <= 1'b0;
                r_exp    <= 1'b0;
            end else begin
                if (w_wr && (w_reg == c_REG_CNTL)) begin
                    r_reload <= COUNT_W'({w_reload16[15:8], din});
                end
                if (w_wr && (w_reg == c_REG_CNTH)) begin
                    r_reload <= COUNT_W'({din, w_reload16[7:0]});
                end
                // Snapshot is the pre-decrement count of this cycle
                if (w_rd && (w_reg == c_REG_CNTL)) begin
                    r_shadow <= w_count16[15:8];
                end
                // Clear first so a same-cycle expiry below overrides it
                if (w_wr && (w_reg == c_REG_STATUS) && din[0]) begin
                    r_exp <= 1'b0;
                end
                // Enabling loads the reload value and ignores this cycle's tick
                if (w_en_rise) begin
                    r_count <= r_reload;
                end else if (w_tick && r_en) begin
                    if (r_count != '0) begin
                        r_count <= r_count - COUNT_W'(1);
                    end else begin
                        r_exp <= 1'b1;
                        if (r_per) begin
                            r_count <= r_reload;
                        end else begin
                            r_en <= 1'b0;
                        end
                    end
                end
                // Last assignment: a CTRL write beats the one-shot auto-disable
                if (w_wr && (w_reg == c_REG_CTRL)) begin
                    r_en  <= din[0];
                    r_per <= din[1];
                    r_ie  <= din[2];
                end
            end
        end

        // Register file view of this channel
        always_comb begin
            w_rdata = 8'h00;
            case (w_reg)
                c_REG_CNTL: w_rdata = w_count16[7:0];
                c_REG_CNTH: w_rdata = r_shadow;
                c_REG_CTRL: w_rdata = {5'b00000, r_ie, r_per, r_en};
                default:    w_rdata = {7'b0000000, r_exp};
            endcase
        end

        assign w_rmask[g]   = w_sel ? w_rdata : 8'h00;
        assign w_irq_req[g] = r_exp & r_ie;
    end

    // ------------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------------
    logic r_irq_n;

    // OR of channel lanes; absent channels and deselected page read as zero
    always_comb begin
        dout = 8'h00;
        if (cs) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                dout = dout | w_rmask[i];
            end
        end
    end

    // Interrupt follows the expiry/enable state with one cycle of latency
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_irq_n <= 1'b1;
        end else begin
            r_irq_n <= ~(|w_irq_req);
        end
    end

    assign irq_n = r_irq_n;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_bank
//  Description : Directed self-checking bench for timer_bank
//                (4 channels, 10-bit counters, tick every 4 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_bank;

    localparam int NT = 4;
    localparam int CW = 10;
    localparam int TD = 4;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs      = 1'b0;
    logic       rd_n    = 1'b1;
    logic       wr_n    = 1'b1;
    logic [7:0] addr    = 8'h00;
    logic [7:0] din     = 8'h00;
    logic [7:0] dout;
    logic       irq_n;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pm       = 0;

    timer_bank #(
        .NUM_TIMERS (NT),
        .COUNT_W    (CW),
        .TICK_DIV   (TD)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .cs      (cs),
        .addr    (addr),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .din     (din),
        .dout    (dout),
        .irq_n   (irq_n)
    );

    always #5 clk_sys = ~clk_sys;

    // Cycle counter and expected prescaler phase (tick follows a phase of TD-1)
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (!reset_n) pm <= 0;
        else          pm <= (pm == TD - 1) ? 0 : pm + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge
    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; cs = 1'b1; wr_n = 1'b0;
        @(negedge clk_sys);
        wr_n = 1'b1; cs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic cpu_rd(input logic [7:0] a, output logic [7:0] d);
        addr = a; cs = 1'b1; rd_n = 1'b0;
        #1 d = dout;
        @(negedge clk_sys);
        rd_n = 1'b1; cs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        addr = a; cs = 1'b1;
        #1 d = dout;
        cs = 1'b0;
    endtask

    // Return at the falling edge just before a tick edge
    task automatic align();
        for (int k = 0; k < 2 * TD && pm != TD - 1; k++) @(negedge clk_sys);
        if (pm != TD - 1) begin
            $display("FAIL align: prescaler phase %0d never reached %0d", pm, TD - 1);
            $fatal(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         c1;
        int         c2;
        bit         found;

        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;

        // Reset state
        #1;
        check("rst_irq_n", 16'(irq_n), 16'h1);
        check("rst_dout_cs0", 16'(dout), 16'h00);
        peek(8'h00, d); check("rst_cntl0", 16'(d), 16'h00);
        peek(8'h02, d); check("rst_ctrl0", 16'(d), 16'h00);
        @(negedge clk_sys);

        // Periodic channel 0, reload 2 -> expiry every 12 clocks, IRQ one clock later
        cpu_wr(8'h00, 8'h02);
        cpu_wr(8'h01, 8'h00);
        cpu_wr(8'h02, 8'h07);
        addr = 8'h03; cs = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk_sys); #1;
            if (dout[0]) found = 1'b1;
        end
        c1 = cyc;
        check("t2_first_expiry", 16'(found), 16'h1);
        check("t2_irq_still_high", 16'(irq_n), 16'h1);
        @(negedge clk_sys); #1;
        check("t2_irq_low", 16'(irq_n), 16'h0);
        cs = 1'b0;
        cpu_wr(8'h03, 8'h01);
        peek(8'h03, d); check("t2_status_cleared", 16'(d), 16'h00);
        check("t2_irq_released", 16'(irq_n), 16'h1);
        addr = 8'h03; cs = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk_sys); #1;
            if (dout[0]) found = 1'b1;
        end
        c2 = cyc;
        check("t2_second_expiry", 16'(found), 16'h1);
        check("t2_period", 16'(c2 - c1), 16'd12);
        cs = 1'b0;
        @(negedge clk_sys);
        cpu_wr(8'h02, 8'h00);
        cpu_wr(8'h03, 8'h01);
        check("t2_irq_off", 16'(irq_n), 16'h1);

        // One-shot channel 1 with reload 0
        cpu_wr(8'h04, 8'h00);
        cpu_wr(8'h05, 8'h00);
        cpu_wr(8'h06, 8'h01);
        repeat (8) @(negedge clk_sys);
        peek(8'h07, d); check("t3_expired", 16'(d), 16'h01);
        peek(8'h06, d); check("t3_ctrl_auto_off", 16'(d), 16'h00);
        peek(8'h04, d); check("t3_count_zero", 16'(d), 16'h00);
        check("t3_no_irq", 16'(irq_n), 16'h1);

        // Snapshot on channel 2 with count 0x0100
        cpu_wr(8'h08, 8'h00);
        cpu_wr(8'h09, 8'h01);
        align();
        cpu_wr(8'h0A, 8'h01);
        cpu_rd(8'h08, d); check("t4_cntl_read", 16'(d), 16'h00);
        @(negedge clk_sys);
        peek(8'h08, d); check("t4_after_tick", 16'(d), 16'hFF);
        cpu_rd(8'h09, d); check("t4_shadow", 16'(d), 16'h01);
        peek(8'h08, d); check("t4_live_count", 16'(d), 16'hFF);
        cpu_wr(8'h0A, 8'h00);

        // Channel 3: clear on the expiry edge, then a held write across an expiry
        cpu_wr(8'h0C, 8'h01);
        cpu_wr(8'h0D, 8'h00);
        align();
        cpu_wr(8'h0E, 8'h03);
        repeat (6) @(negedge clk_sys);
        cpu_wr(8'h0F, 8'h01);
        peek(8'h0F, d); check("t5_set_wins", 16'(d), 16'h01);
        addr = 8'h0F; din = 8'h01; cs = 1'b1; wr_n = 1'b0;
        @(negedge clk_sys); #1;
        check("t5_held_clears_once", 16'(dout), 16'h00);
        repeat (7) @(negedge clk_sys);
        #1;
        check("t5_held_no_reclear", 16'(dout), 16'h01);
        wr_n = 1'b1; cs = 1'b0;
        @(negedge clk_sys);
        cpu_wr(8'h0E, 8'h00);

        // Absent channel and counter-width truncation
        cpu_wr(8'h12, 8'h07);
        peek(8'h02, d); check("t6_no_alias_ctrl0", 16'(d), 16'h00);
        cpu_rd(8'h12, d); check("t6_absent_read", 16'(d), 16'h00);
        check("t6_irq_high", 16'(irq_n), 16'h1);
        cpu_wr(8'h00, 8'h00);
        cpu_wr(8'h01, 8'hFF);
        align();
        cpu_wr(8'h02, 8'h01);
        cpu_rd(8'h00, d); check("t6_cntl_trunc", 16'(d), 16'h00);
        cpu_rd(8'h01, d); check("t6_cnth_trunc", 16'(d), 16'h03);
        cpu_wr(8'h02, 8'h00);

        // Reset while running with an interrupt pending
        cpu_wr(8'h06, 8'h04);
        check("t1_irq_before_reset", 16'(irq_n), 16'h0);
        cpu_wr(8'h0E, 8'h03);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        #1;
        check("t1_irq_after_reset", 16'(irq_n), 16'h1);
        for (int a = 0; a < 4 * NT; a++) begin
            peek(8'(a), d);
            check($sformatf("t1_reg_%02h", a), 16'(d), 16'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
